// File: rtl/canvas_port_arbiter.sv
// canvas_port_arbiter
//   Shares the single-port canvas colour RAM between display scanout reads,
//   buffered game-logic writes and a bulk-clear sequencer.
//   Fixed priority: display read > clear write > FIFO write > idle.
//
// Ports
//   CLK25MHZ, reset               pixel clock, synchronous active-high reset
//   disp_req/disp_addr            display read request (never stalls)
//   disp_valid/disp_data          read data, one cycle after the request
//   wr_valid/wr_ready/wr_addr/wr_data   game write, valid/ready into FIFO
//   clr_start/clr_color/clr_busy  full-canvas clear control
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   RAM port
//
// Clear FSM
//   state    | meaning
//   ST_IDLE  | no clear running, FIFO may drain
//   ST_CLEAR | writing clr_color to every address, FIFO held
module canvas_port_arbiter #(
  parameter int CANVAS_SIZE = 16,
  parameter int ADDR_W      = 8,
  parameter int COLOR_W     = 12,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               CLK25MHZ,
  input  logic               reset,
  input  logic               disp_req,
  input  logic [ADDR_W-1:0]  disp_addr,
  output logic               disp_valid,
  output logic [COLOR_W-1:0] disp_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic               clr_start,
  input  logic [COLOR_W-1:0] clr_color,
  output logic               clr_busy,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CANVAS_SIZE * CANVAS_SIZE - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ADDR_W-1:0]  r_clr_cnt;
  logic [COLOR_W-1:0] r_clr_color;
  logic               r_disp_valid;

  logic [ADDR_W-1:0]  r_fifo_addr [FIFO_DEPTH];
  logic [COLOR_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_gnt_disp;
  logic w_gnt_clr;
  logic w_gnt_fifo;
  logic w_push;
  logic w_clr_accept;

  // All grants are masked by reset so nothing reaches the RAM while a
  // pending clear or FIFO content is being abandoned.
  assign w_gnt_disp   = !reset && disp_req;
  assign w_gnt_clr    = !reset && !disp_req && (r_state == ST_CLEAR);
  assign w_gnt_fifo   = !reset && !disp_req && (r_state == ST_IDLE) && (r_count != '0);
  assign w_clr_accept = (r_state == ST_IDLE) && clr_start;

  assign wr_ready = !reset && (r_count < CNT_W'(FIFO_DEPTH));
  assign w_push   = wr_valid && wr_ready;

  // ---------------- clear FSM ----------------
  always_ff @(posedge CLK25MHZ) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (clr_start) w_state_next = ST_CLEAR;
      ST_CLEAR: if (w_gnt_clr && (r_clr_cnt == LAST_ADDR)) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (r_state == ST_CLEAR) && !reset;
  end

  // Counter advances only on granted clear writes; colour is latched only
  // when a start is accepted, so a start during a clear changes nothing.
  always_ff @(posedge CLK25MHZ) begin
    if (reset) begin
      r_clr_cnt   <= '0;
      r_clr_color <= '0;
    end else if (w_clr_accept) begin
      r_clr_cnt   <= '0;
      r_clr_color <= clr_color;
    end else if (w_gnt_clr) begin
      r_clr_cnt <= (r_clr_cnt == LAST_ADDR) ? '0 : r_clr_cnt + ADDR_W'(1);
    end
  end

  // ---------------- write FIFO ----------------
  always_ff @(posedge CLK25MHZ) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= wr_addr;
      r_fifo_data[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge CLK25MHZ) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_gnt_fifo) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_gnt_fifo})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- display read path ----------------
  always_ff @(posedge CLK25MHZ) begin
    r_disp_valid <= disp_req && !reset;
  end

  assign disp_valid = r_disp_valid;
  assign disp_data  = mem_rdata;

  // ---------------- RAM port mux ----------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt_disp) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (w_gnt_clr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = r_clr_cnt;
      mem_wdata = r_clr_color;
    end else if (w_gnt_fifo) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = r_fifo_addr[r_rd_ptr];
      mem_wdata = r_fifo_data[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_canvas_port_arbiter.sv
// Directed bench for canvas_port_arbiter with a behavioural single-port RAM.
module tb_canvas_port_arbiter;

  logic        CLK25MHZ = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [7:0]  disp_addr;
  logic        disp_valid;
  logic [11:0] disp_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [11:0] wr_data;
  logic        clr_start;
  logic [11:0] clr_color;
  logic        clr_busy;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata = '0;

  logic [11:0] ram [256];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [11:0] pre_data;
  int          n_writes = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #20 CLK25MHZ = ~CLK25MHZ;

  canvas_port_arbiter dut (
    .CLK25MHZ  (CLK25MHZ),
    .reset     (reset),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_valid(disp_valid),
    .disp_data (disp_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // RAM model: synchronous read, one-cycle latency; preload port for setup.
  always @(posedge CLK25MHZ) begin
    if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
      n_writes++;
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK25MHZ);
  endtask

  initial begin
    #8000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int seq_err;
    int ram_err;
    int wr_mark;

    reset = 1'b1; disp_req = 1'b0; disp_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clr_start = 1'b0; clr_color = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    // ---- reset with RAM preload ----
    tick(); pre_we = 1'b1; pre_addr = 8'h00; pre_data = 12'hF00; #1;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_clr_busy", clr_busy, 0);
    tick(); pre_addr = 8'h01; pre_data = 12'h0F0; #1;
    check("rst_disp_valid", disp_valid, 0);
    tick(); pre_addr = 8'h02; pre_data = 12'h00F;
    tick(); pre_we = 1'b0; reset = 1'b0; #1;
    check("post_rst_wr_ready", wr_ready, 1);
    check("post_rst_clr_busy", clr_busy, 0);
    check("post_rst_mem_en", mem_en, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("idle_disp_valid", disp_valid, 0);
      check("idle_mem_en", mem_en, 0);
      check("idle_wr_ready", wr_ready, 1);
    end

    // ---- back-to-back display reads ----
    tick(); disp_req = 1'b1; disp_addr = 8'h00; #1;
    check("rd_mem_en", mem_en, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_addr", mem_addr, 8'h00);
    tick(); disp_addr = 8'h01; #1;
    check("rd0_valid", disp_valid, 1);
    check("rd0_data", disp_data, 12'hF00);
    tick(); disp_addr = 8'h02; #1;
    check("rd1_valid", disp_valid, 1);
    check("rd1_data", disp_data, 12'h0F0);
    tick(); disp_req = 1'b0; #1;
    check("rd2_valid", disp_valid, 1);
    check("rd2_data", disp_data, 12'h00F);
    tick(); #1;
    check("rd_end_valid", disp_valid, 0);

    // ---- FIFO fill while display holds the port ----
    disp_req = 1'b1; disp_addr = 8'h80;
    for (int i = 0; i < 5; i++) begin
      tick(); wr_valid = 1'b1; wr_addr = 8'h10 + 8'(i); wr_data = 12'hABC; #1;
      check("fill_wr_ready", wr_ready, (i < 4) ? 1 : 0);
      check("fill_mem_we", mem_we, 0);
    end
    tick(); disp_req = 1'b0; #1;
    check("drain0_addr", mem_addr, 8'h10);
    check("drain0_we", mem_we, 1);
    check("drain0_data", mem_wdata, 12'hABC);
    check("drain0_wr_ready", wr_ready, 0);
    tick(); #1;
    check("drain1_addr", mem_addr, 8'h11);
    check("drain1_wr_ready", wr_ready, 1);
    tick(); wr_valid = 1'b0; #1;
    check("drain2_addr", mem_addr, 8'h12);
    tick(); #1;
    check("drain3_addr", mem_addr, 8'h13);
    tick(); #1;
    check("drain4_addr", mem_addr, 8'h14);
    check("drain4_we", mem_we, 1);
    tick(); #1;
    check("drain_done_en", mem_en, 0);

    // ---- full clear with ignored restart and a write during the clear ----
    tick(); clr_start = 1'b1; clr_color = 12'h123; #1;
    check("clr_start_busy", clr_busy, 0);
    busy_cycles = 0; seq_err = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      clr_start = (i == 100);
      clr_color = (i == 100) ? 12'h456 : 12'h123;
      wr_valid  = (i == 10);
      wr_addr   = 8'h05;
      wr_data   = 12'hFFF;
      #1;
      if (clr_busy) busy_cycles++;
      if (!(mem_en && mem_we && mem_addr == 8'(i) && mem_wdata == 12'h123)) seq_err++;
    end
    check("clr_seq_errors", seq_err, 0);
    check("clr_busy_cycles", busy_cycles, 256);
    tick(); clr_start = 1'b0; wr_valid = 1'b0; #1;
    check("clr_end_busy", clr_busy, 0);
    check("clr_fifo_addr", mem_addr, 8'h05);
    check("clr_fifo_data", mem_wdata, 12'hFFF);
    tick(); #1;
    check("clr_after_en", mem_en, 0);
    check("clr_no_restart", clr_busy, 0);
    ram_err = 0;
    for (int a = 0; a < 256; a++)
      if (ram[a] !== ((a == 5) ? 12'hFFF : 12'h123)) ram_err++;
    check("clr_ram_content", ram_err, 0);
    disp_req = 1'b1; disp_addr = 8'h05;
    tick(); disp_addr = 8'h06; #1;
    check("clr_rd5", disp_data, 12'hFFF);
    tick(); disp_req = 1'b0; #1;
    check("clr_rd6", disp_data, 12'h123);

    // ---- reset in the middle of a clear with FIFO entries pending ----
    tick(); clr_start = 1'b1; clr_color = 12'h777;
    wr_mark = 0;
    for (int i = 0; i <= 50; i++) begin
      tick();
      clr_start = 1'b0;
      wr_valid  = (i == 5) || (i == 6);
      wr_addr   = (i == 5) ? 8'hA0 : 8'hA1;
      wr_data   = 12'h999;
      if (i == 50) reset = 1'b1;
      #1;
      if (i == 49) check("rst_clr_addr49", mem_addr, 8'd49);
      if (i == 50) begin
        check("midrst_mem_en", mem_en, 0);
        check("midrst_busy", clr_busy, 0);
        wr_mark = n_writes;
      end
    end
    tick(); reset = 1'b0; wr_valid = 1'b0; #1;
    check("midrst_after_busy", clr_busy, 0);
    check("midrst_after_en", mem_en, 0);
    for (int i = 0; i < 20; i++) tick();
    #1;
    check("midrst_no_writes", n_writes - wr_mark, 0);
    ram_err = 0;
    for (int a = 0; a < 50; a++)
      if (ram[a] !== 12'h777) ram_err++;
    check("midrst_low_cleared", ram_err, 0);
    ram_err = 0;
    for (int a = 50; a < 256; a++)
      if (ram[a] !== 12'h123) ram_err++;
    check("midrst_high_untouched", ram_err, 0);
    check("midrst_fifo_a0", ram[8'hA0], 12'h123);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/canvas_port_arbiter.md
Name: canvas_port_arbiter

Overview:
- Shares the single-port 256-entry canvas colour RAM (16x16, 12-bit RGB) between three requesters: display scanout reads, game-logic pixel writes, and a built-in bulk-clear sequencer.
- Sits between the game logic, the VGA pixel pipeline and the canvas RAM, all in the CLK25MHZ domain.
- Display reads have absolute priority and never stall.
- Game writes are buffered in a small FIFO and drained in free cycles.

Parameters:
- CANVAS_SIZE, 16, canvas edge in blocks; RAM depth is CANVAS_SIZE*CANVAS_SIZE.
- ADDR_W, 8, RAM address width; equals $clog2(CANVAS_SIZE*CANVAS_SIZE).
- COLOR_W, 12, pixel width as {r[3:0], g[3:0], b[3:0]}.
- FIFO_DEPTH, 4, write FIFO entries; power of two, at least 2.

Ports:
- CLK25MHZ  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- disp_req  in  1  display requests a read this cycle.
- disp_addr  in  ADDR_W  display read address.
- disp_valid  out  1  disp_data holds read data for the request made in the previous cycle.
- disp_data  out  COLOR_W  read data; equals mem_rdata.
- wr_valid  in  1  game write request.
- wr_ready  out  1  FIFO can accept a write.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  COLOR_W  write colour.
- clr_start  in  1  one-cycle pulse that starts a full-canvas clear.
- clr_color  in  COLOR_W  fill colour, sampled on the accepted clr_start.
- clr_busy  out  1  clear in progress.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable (1 = write, 0 = read).
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  COLOR_W  RAM write data.
- mem_rdata  in  COLOR_W  RAM read data; valid one cycle after a read.

Behaviour:
- Reset values: disp_valid=0, wr_ready=0 during reset and 1 in the first cycle after reset, clr_busy=0, mem_en=0, mem_we=0. FIFO is emptied and the clear counter is set to 0.
- Reset mid-clear or with the FIFO non-empty: both are abandoned and no further RAM writes are issued.
- Arbitration is fixed priority, decided combinationally each cycle, with mem_* driven combinationally:
  - 1. disp_req=1: read disp_addr (mem_en=1, mem_we=0).
  - 2. Otherwise, if clr_busy=1: write clr_color at the clear counter.
  - 3. Otherwise, if the FIFO is non-empty: pop the head and write it.
  - 4. Otherwise: mem_en=0.
- Read latency:
  - disp_valid is a registered copy of (disp_req && !reset).
  - disp_data = mem_rdata whenever disp_valid=1.
  - Back-to-back reads every cycle are supported with full throughput.
- Write FIFO:
  - Push when wr_valid && wr_ready.
  - wr_ready = !reset && (count < FIFO_DEPTH), using the registered count. A cycle where the FIFO is full and a pop occurs does not accept a push; wr_ready rises the following cycle.
  - An entry pushed in cycle N is eligible for the RAM no earlier than cycle N+1.
  - Writes reach the RAM in FIFO order.
  - Pop and push in the same cycle keep the count unchanged.
- Clear sequencer, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start: latch clr_color, counter=0, clr_busy=1 in the next cycle.
  - In CLEAR, the counter increments only on cycles when a clear write is granted.
  - After the write to address CANVAS_SIZE*CANVAS_SIZE-1 is granted, go to IDLE: clr_busy=0 next cycle and counter back to 0. No wrap-around rewrite.
  - clr_start while clr_busy=1 is ignored, including any clr_color change.
  - During CLEAR, FIFO pushes are still accepted but not drained. They drain after the clear, so game writes made during a clear survive it.
- Throughput with no display reads:
  - A clear takes exactly 256 cycles.
  - A full FIFO drains in FIFO_DEPTH cycles.
- Starvation of clear and FIFO during continuous disp_req is accepted. The display asserts disp_req only inside the 256x256 canvas window, which leaves horizontal and vertical blanking free.

Test Plan:
- Reset, then idle: disp_valid=0, clr_busy=0, mem_en=0 throughout, and wr_ready=1 from the first cycle after reset.
- disp_req=1 with disp_addr=0x00,0x01,0x02 on consecutive cycles, RAM preloaded with 0xF00,0x0F0,0x00F -> disp_valid=1 on the next three cycles with disp_data 0xF00,0x0F0,0x00F.
- Five back-to-back wr_valid writes (addr 0x10..0x14, data 0xABC) while disp_req=1 holds the port -> first four accepted, wr_ready=0 on the fifth. Release disp_req -> four RAM writes in order 0x10..0x13, then the fifth is accepted.
- clr_start with clr_color=0x123 and no display traffic -> clr_busy high for exactly 256 cycles, every address is written 0x123, and a second clr_start at cycle 100 has no effect.
- During a clear, push a write addr=0x05 data=0xFFF -> after clr_busy falls, address 0x05 reads 0xFFF and all other addresses read 0x123.
- Assert reset at clear cycle 50 with two FIFO entries pending -> clr_busy=0 and no mem_we after reset. Addresses 50..255 are not written to clr_color, and the pending FIFO entries are not written.
